// File: rtl/cnn_maxpool_3x3s2.sv
// cnn_maxpool_3x3s2
//   Streaming 3x3 / stride 2 / pad 1 max-pool over IEEE-754 single-precision
//   channel maps. Each map arrives in raster order, one channel after another.
//   The pool is split into two stages:
//     - a horizontal stage, which folds each 3-wide column window into one value
//     - a vertical stage, which folds three such row results using a W/2 line buffer
//   There is no backpressure and no frame storage.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   valid_in   pxl_in carries a pixel this cycle
//   pxl_in     input pixel (raster order within the channel map)
//   pxl_out    pooled pixel; holds its value while valid_out is low
//   valid_out  one-cycle pulse per pooled pixel, 2 clk after in(2r+1,2c+1)
//
// Handshake: valid_in is a plain valid with no ready. Every valid_in cycle is
// consumed. valid_out is a plain valid with no ready, and the consumer must
// accept every pulse.
module cnn_maxpool_3x3s2 #(
  parameter int DATA_WIDTH   = 32,
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128,
  parameter int CHANNEL_NUM  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out
);

  localparam int COL_W = $clog2(IMAGE_WIDTH);
  localparam int ROW_W = $clog2(IMAGE_HEIGHT);
  localparam int CH_W  = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
  localparam int LB_W  = COL_W - 1;
  localparam logic [DATA_WIDTH-1:0] NEG_INF = DATA_WIDTH'(32'hFF80_0000);

  // Float max with an a>=b compare on sign/magnitude. NaN is not handled.
  // The result for -0.0 vs +0.0 may be either zero.
  function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    logic a_ge_b;
    if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
      a_ge_b = ~a[DATA_WIDTH-1];
    else if (!a[DATA_WIDTH-1])
      a_ge_b = (a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0]);
    else
      a_ge_b = (a[DATA_WIDTH-2:0] <= b[DATA_WIDTH-2:0]);
    return a_ge_b ? a : b;
  endfunction

  // Position counters
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CH_W-1:0]  ch_q,  ch_d;

  // Horizontal stage
  logic [DATA_WIDTH-1:0] hacc_q, hacc_d;
  logic [DATA_WIDTH-1:0] prev_odd_q, prev_odd_d;
  logic [DATA_WIDTH-1:0] hmax_q, hmax_d;
  logic                  hmax_v_q, hmax_v_d;
  logic                  hrow_odd_q, hrow_odd_d;
  logic                  hrow_zero_q, hrow_zero_d;
  logic [LB_W-1:0]       hcol_q, hcol_d;

  // Vertical stage and output
  logic [DATA_WIDTH-1:0] lb_q [IMAGE_WIDTH/2];
  logic [DATA_WIDTH-1:0] lb_rd, lb_top, lb_wdata;
  logic [DATA_WIDTH-1:0] pxl_out_q, pxl_out_d;
  logic                  valid_out_q, valid_out_d;
  logic [DATA_WIDTH-1:0] h_left;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    ch_d  = ch_q;
    if (valid_in) begin
      if (col_q == COL_W'(IMAGE_WIDTH - 1)) begin
        col_d = '0;
        if (row_q == ROW_W'(IMAGE_HEIGHT - 1)) begin
          row_d = '0;
          ch_d  = (ch_q == CH_W'(CHANNEL_NUM - 1)) ? '0 : ch_q + 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Even column 2c pairs with the odd column 2c-1 on its left.
  // For c=0 that left tap lies outside the map, so it is -inf.
  always_comb begin
    h_left      = (col_q < COL_W'(2)) ? NEG_INF : prev_odd_q;
    hacc_d      = hacc_q;
    prev_odd_d  = prev_odd_q;
    hmax_d      = hmax_q;
    hmax_v_d    = 1'b0;
    hrow_odd_d  = hrow_odd_q;
    hrow_zero_d = hrow_zero_q;
    hcol_d      = hcol_q;
    if (valid_in) begin
      if (!col_q[0]) begin
        hacc_d = fmax(h_left, pxl_in);
      end else begin
        hmax_d      = fmax(hacc_q, pxl_in);
        prev_odd_d  = pxl_in;
        hmax_v_d    = 1'b1;
        hrow_odd_d  = row_q[0];
        hrow_zero_d = (row_q == '0);
        hcol_d      = col_q[COL_W-1:1];
      end
    end
  end

  // Even rows accumulate into LB. Masking row 0 to -inf provides the top pad
  // and also hides whatever the previous channel left in LB.
  // Odd rows close the window, and their own value seeds the next window's top tap.
  always_comb begin
    lb_rd       = lb_q[hcol_q];
    lb_top      = hrow_zero_q ? NEG_INF : lb_rd;
    lb_wdata    = hrow_odd_q ? hmax_q : fmax(lb_top, hmax_q);
    pxl_out_d   = pxl_out_q;
    valid_out_d = 1'b0;
    if (hmax_v_q && hrow_odd_q) begin
      pxl_out_d   = fmax(lb_rd, hmax_q);
      valid_out_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      ch_q        <= '0;
      hacc_q      <= NEG_INF;
      prev_odd_q  <= NEG_INF;
      hmax_q      <= NEG_INF;
      hmax_v_q    <= 1'b0;
      hrow_odd_q  <= 1'b0;
      hrow_zero_q <= 1'b0;
      hcol_q      <= '0;
      pxl_out_q   <= '0;
      valid_out_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      ch_q        <= ch_d;
      hacc_q      <= hacc_d;
      prev_odd_q  <= prev_odd_d;
      hmax_q      <= hmax_d;
      hmax_v_q    <= hmax_v_d;
      hrow_odd_q  <= hrow_odd_d;
      hrow_zero_q <= hrow_zero_d;
      hcol_q      <= hcol_d;
      pxl_out_q   <= pxl_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  // The line buffer needs no reset: a read returns the old value,
  // and every entry is overwritten on row 0 before it is used.
  always_ff @(posedge clk) begin
    if (hmax_v_q)
      lb_q[hcol_q] <= lb_wdata;
  end

  assign pxl_out   = pxl_out_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_cnn_maxpool_3x3s2.sv
module tb_cnn_maxpool_3x3s2;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         valid_in = 1'b0;
  logic [W-1:0] pxl_in = '0;
  logic [W-1:0] pxl_out;
  logic         valid_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  int           exp_t_q[$];
  logic [W-1:0] last_out = '0;

  cnn_maxpool_3x3s2 #(
    .DATA_WIDTH(32), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .CHANNEL_NUM(2)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .pxl_out(pxl_out), .valid_out(valid_out)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus tables
  logic [W-1:0] ramp [16] = '{
    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
    32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
    32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
  logic [W-1:0] ramp_exp [4] = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
  logic [W-1:0] nramp_exp [4] = '{32'hBF800000, 32'hC0000000, 32'hC0A00000, 32'hC0C00000};
  logic [W-1:0] px [16];
  logic [W-1:0] ex [4];

  // Driver tasks
  task automatic do_reset();
    @(posedge clk); #2 reset = 1'b1; valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
  endtask

  // Pixel index i of a 4x4 map triggers an output when it is in(odd row, odd col).
  function automatic int trig_idx(input int i);
    case (i)
      5: return 0;
      7: return 1;
      13: return 2;
      15: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic send_frame(input logic [W-1:0] p [16], input logic [W-1:0] e [4],
                            input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_in = 1'b1;
      pxl_in   = p[i];
      if (trig_idx(i) >= 0) begin
        exp_q.push_back(e[trig_idx(i)]);
        exp_t_q.push_back(cyc + 2);
      end
      if (gaps) idle(1);
    end
  endtask

  task automatic end_test(input string name);
    idle(8);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s drained: %0d expected outputs missing, required 0", name, exp_q.size());
      exp_q.delete();
      exp_t_q.delete();
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (valid_out !== 1'b0 || pxl_out !== '0) begin
        failures++;
        $display("FAIL reset_state: valid_out=%b pxl_out=%h, required 0/00000000", valid_out, pxl_out);
      end
      last_out = '0;
    end else if (valid_out === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out: pxl_out=%h at cycle %0d, required no output", pxl_out, cyc);
      end else begin
        logic [W-1:0] e;
        int t;
        e = exp_q.pop_front();
        t = exp_t_q.pop_front();
        if (pxl_out !== e) begin
          failures++;
          $display("FAIL out_value: got %h, required %h", pxl_out, e);
        end
        checks++;
        if (cyc != t) begin
          failures++;
          $display("FAIL out_latency: got cycle %0d, required %0d", cyc, t);
        end
      end
      last_out = pxl_out;
    end else begin
      checks++;
      if (valid_out !== 1'b0 || pxl_out !== last_out) begin
        failures++;
        $display("FAIL hold: valid_out=%b pxl_out=%h, required 0/%h", valid_out, pxl_out, last_out);
      end
    end
  end

  initial begin
    // 1 ramp, back-to-back
    do_reset();
    send_frame(ramp, ramp_exp, 16, 1'b0);
    end_test("ramp");

    // 2 all -1.0: outputs stay -1.0, so padding is -inf and not 0
    for (int i = 0; i < 16; i++) px[i] = 32'hBF800000;
    for (int i = 0; i < 4; i++) ex[i] = 32'hBF800000;
    do_reset();
    send_frame(px, ex, 16, 1'b0);
    end_test("all_neg");

    // 3a -0.5 at in(1,0) among -3.0: only left-column windows see it
    for (int i = 0; i < 16; i++) px[i] = 32'hC0400000;
    px[4] = 32'hBF000000;
    ex[0] = 32'hBF000000; ex[1] = 32'hC0400000; ex[2] = 32'hBF000000; ex[3] = 32'hC0400000;
    do_reset();
    send_frame(px, ex, 16, 1'b0);
    end_test("mixed_a");

    // 3b -0.5 at in(1,1): row 1 and col 1 are shared taps, so all four windows see it
    for (int i = 0; i < 16; i++) px[i] = 32'hC0400000;
    px[5] = 32'hBF000000;
    for (int i = 0; i < 4; i++) ex[i] = 32'hBF000000;
    do_reset();
    send_frame(px, ex, 16, 1'b0);
    end_test("mixed_b");

    // 4 ramp with valid_in toggling
    do_reset();
    send_frame(ramp, ramp_exp, 16, 1'b1);
    end_test("ramp_gaps");

    // 5 two channels back-to-back: ramp, then negated ramp
    for (int i = 0; i < 16; i++) px[i] = ramp[i] | 32'h80000000;
    do_reset();
    send_frame(ramp, ramp_exp, 16, 1'b0);
    send_frame(px, nramp_exp, 16, 1'b0);
    end_test("two_ch");

    // 6 reset after 7 inputs, then the full ramp from in(0,0)
    do_reset();
    send_frame(ramp, ramp_exp, 7, 1'b0);
    idle(1);
    do_reset();
    idle(3);
    send_frame(ramp, ramp_exp, 16, 1'b0);
    end_test("mid_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Overall time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
